display_scan_driver: RTL and testbench

Upstream feeder for the 7-segment decoder. It takes a binary value from 0 to 9999 on a load strobe and converts it to 4-digit BCD with a sequential double-dabble engine. It then time-multiplexes the four digits onto one 4-bit nibble bus and an active-low one-hot anode bus. `digit_data` drives the decoder input directly; a nibble of 4'hF is the blank code, which the decoder renders as all segments off.

---
 rtl/display_scan_driver.sv | 122 ++++++++++++
 tb/tb_display_scan_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit
// time-multiplexed scan bus with optional leading-zero blanking.
module display_scan_driver #(
    parameter int REFRESH_DIV = 27000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] bin_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic        busy,
    output logic        ovf,
    output logic [15:0] bcd_out,
    output logic [3:0]  digit_data,
    output logic [3:0]  anodes
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t      state, state_nx;
    logic [13:0] binreg;
    logic [15:0] scratch;
    logic [15:0] scratch_adj;
    logic [3:0]  shcnt;
    logic        ovf_pending;
    logic [13:0] clamped;
    logic [PW-1:0] presc;
    logic [1:0]  idx;
    logic        upper_zero;

    assign clamped = (bin_in > 14'd9999) ? 14'd9999 : bin_in;
    assign busy    = (state != IDLE);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: default assignment first so no path through the block leaves a variable unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = CONVERT;
            CONVERT: if (shcnt == 4'd1) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binreg      <= '0;
            scratch     <= '0;
            shcnt       <= '0;
            ovf_pending <= 1'b0;
            bcd_out     <= '0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    binreg      <= clamped;
                    scratch     <= '0;
                    shcnt       <= 4'd14;
                    ovf_pending <= (bin_in > 14'd9999);
                end
                CONVERT: begin
                    {scratch, binreg} <= {scratch_adj, binreg} << 1;
                    shcnt             <= shcnt - 4'd1;
                end
                COMMIT: begin
                    bcd_out <= scratch;
                    ovf     <= ovf_pending;
                end
                default: ;
            endcase
        end
    end

    // Free-running refresh prescaler; slot index advances on its terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_TC) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A slot is blank when it and every more-significant digit are zero; units never blanks.
    always_comb begin
        upper_zero = 1'b0;
        case (idx)
            2'd1:    upper_zero = (bcd_out[15:4]  == 12'd0);
            2'd2:    upper_zero = (bcd_out[15:8]  == 8'd0);
            2'd3:    upper_zero = (bcd_out[15:12] == 4'd0);
            default: upper_zero = 1'b0;
        endcase
        if (blank_lz && upper_zero) begin
            anodes     = 4'b1111;
            digit_data = 4'hF;
        end else begin
            anodes     = ~(4'b0001 << idx);
            digit_data = bcd_out[{idx, 2'b00} +: 4];
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver: commits are checked by a monitor
// against queued expectations; scan frames are checked against a slot-timing model.
module tb_display_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] bin_in;
    logic        load;
    logic        blank_lz;
    logic        busy;
    logic        ovf;
    logic [15:0] bcd_out;
    logic [3:0]  digit_data;
    logic [3:0]  anodes;

    display_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bin_in     (bin_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .busy       (busy),
        .ovf        (ovf),
        .bcd_out    (bcd_out),
        .digit_data (digit_data),
        .anodes     (anodes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    logic prev_busy = 1'b0;

    // Slot-timing reference: 4 cycles per slot, 4 slots, restarted by reset.
    logic [1:0] m_presc;
    logic [1:0] m_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_presc <= 2'd0;
            m_idx   <= 2'd0;
        end else if (m_presc == 2'd3) begin
            m_presc <= 2'd0;
            m_idx   <= m_idx + 2'd1;
        end else begin
            m_presc <= m_presc + 2'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a busy fall outside reset is a commit; compare against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL commit_unexpected: got bcd=%h ovf=%b with nothing expected", bcd_out, ovf);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("commit_bcd_ovf", {15'd0, bcd_out, ovf}, {15'd0, e.bcd, e.ovf});
                end
            end
            prev_busy = busy;
        end
    end

    task automatic do_load(input logic [13:0] v, input logic [15:0] eb, input logic eo, input bit push);
        @(negedge clk);
        bin_in = v;
        load   = 1'b1;
        if (push) exp_q.push_back('{bcd: eb, ovf: eo});
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (busy) begin
            n_vec++;
            n_fail++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", cyc);
        end
    endtask

    // tbl packs {slot3,slot2,slot1,slot0}, each {digit_data, anodes}.
    task automatic scan_frame(input string name, input logic [31:0] tbl);
        logic [31:0] t;
        t = tbl;
        repeat (16) begin
            @(negedge clk);
            check(name, {24'd0, digit_data, anodes}, {24'd0, t[{m_idx, 3'b000} +: 8]});
        end
    endtask

    task automatic reset_pulse_async();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bcd",    {16'd0, bcd_out},  32'h0);
        check("async_rst_ovf",    {31'd0, ovf},      32'h0);
        check("async_rst_busy",   {31'd0, busy},     32'h0);
        check("async_rst_anodes", {28'd0, anodes},   32'hE);
        check("async_rst_digit",  {28'd0, digit_data}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n    = 1'b0;
        load     = 1'b0;
        bin_in   = '0;
        blank_lz = 1'b0;

        // Reset values, then release.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_anodes", {28'd0, anodes},     32'hE);
        check("rst_digit",  {28'd0, digit_data}, 32'h0);
        check("rst_busy",   {31'd0, busy},       32'h0);
        check("rst_ovf",    {31'd0, ovf},        32'h0);
        check("rst_bcd",    {16'd0, bcd_out},    32'h0);

        // 1234: busy sampled high after edges N..N+14, low after N+15.
        do_load(14'd1234, 16'h1234, 1'b0, 1'b1);
        check("busy_after_load", {31'd0, busy}, 32'h1);
        wait_idle(cyc);
        check("latency_1234", cyc, 15);
        scan_frame("scan_1234", 32'h172B3D4E);

        // Overflow clamps to 9999; ovf holds; async reset clears without an edge.
        do_load(14'd10000, 16'h9999, 1'b1, 1'b1);
        wait_idle(cyc);
        repeat (10) @(negedge clk);
        check("hold_bcd", {16'd0, bcd_out}, 32'h9999);
        check("hold_ovf", {31'd0, ovf},     32'h1);
        reset_pulse_async();
        do_load(14'd5, 16'h0005, 1'b0, 1'b1);
        wait_idle(cyc);

        // Load while busy is ignored.
        do_load(14'd42, 16'h0042, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        bin_in = 14'd99;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(cyc);
        repeat (2) @(negedge clk);
        check("ignored_load_no_busy", {31'd0, busy}, 32'h0);
        check("ignored_load_bcd", {16'd0, bcd_out}, 32'h0042);
        scan_frame("scan_42_noblank", 32'h070B4D2E);
        do_load(14'd99, 16'h0099, 1'b0, 1'b1);
        wait_idle(cyc);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        scan_frame("scan_99_blank", 32'hFFFF9D9E);
        do_load(14'd7, 16'h0007, 1'b0, 1'b1);
        wait_idle(cyc);
        scan_frame("scan_7_blank", 32'hFFFFFF7E);
        do_load(14'd0, 16'h0000, 1'b0, 1'b1);
        wait_idle(cyc);
        scan_frame("scan_0_blank", 32'hFFFFFF0E);
        do_load(14'd1005, 16'h1005, 1'b0, 1'b1);
        wait_idle(cyc);
        scan_frame("scan_1005_blank", 32'h170B0D5E);
        blank_lz = 1'b0;

        // Reset mid-conversion aborts; then a full-scale load.
        do_load(14'd8765, 16'h0000, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy},    32'h0);
        check("abort_bcd",  {16'd0, bcd_out}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_load(14'd9999, 16'h9999, 1'b0, 1'b1);
        wait_idle(cyc);

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
